// File: rtl/apb_arb_pkg.sv
// Shared types and default widths for the APB request arbiter.
// No logic; imported by the arbiter top.
package apb_arb_pkg;

    localparam int DEF_NUM_REQ        = 2;
    localparam int DEF_ADDR_W         = 8;
    localparam int DEF_DATA_W         = 8;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

endpackage

// File: rtl/dff.sv
// Generic D flip-flop bank with synchronous active-low reset to RST_VAL.
// Latency: 1 cycle. No flow control.
module dff #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  d,
    output logic [W-1:0]  q
);

    always_ff @(posedge clk) begin
        if (!rst_n) q <= RST_VAL;
        else        q <= d;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible bit at or above ptr, with wrap.
// Latency: 0 cycles. No flow control; any = 0 when nothing is eligible.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]      eligible,
    input  logic [IDX_W-1:0]  ptr,
    output logic [N-1:0]      grant,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);

    int               sum;
    logic [IDX_W-1:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        sum   = 0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            sum = int'(ptr) + k;
            if (sum >= N) sum = sum - N;
            pos = sum[IDX_W-1:0];
            if (!any && eligible[pos]) begin
                any        = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin share of one APB master port among NUM_REQ requesters (APB_ARB_TIMEOUT_EN adds an ACCESS timeout).
// Latency: req at N -> psel N+1, penable N+2, done one cycle after pready (N+3 with no wait states).
// Backpressure: pready stalls ACCESS; requesters hold req until their done pulse.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                        pclk,
    input  logic                        presetn,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          done,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic                        psel,
    output logic                        penable,
    output logic                        pwrite,
    output logic [ADDR_W-1:0]           paddr,
    output logic [DATA_W-1:0]           pwdata,
    input  logic [DATA_W-1:0]           prdata,
    input  logic                        pready,
    input  logic                        pslverr
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("apb_req_arbiter: unsupported parameter set");
    end

    state_t               state, state_nxt;
    logic [STATE_W-1:0]   state_q;
    logic [NUM_REQ-1:0]   eligible, gnt_onehot, owner_oh;
    logic [IDX_W-1:0]     gnt_idx, owner_idx, rr_ptr;
    logic                 gnt_any, load, finish, ack, timeout_hit;

    dff #(.W(STATE_W), .RST_VAL(IDLE)) u_state (
        .clk   (pclk),
        .rst_n (presetn),
        .d     (state_nxt),
        .q     (state_q)
    );
    assign state = state_t'(state_q);

    // The done bit still high this cycle masks the requester that just finished.
    assign eligible = req & ~done;

    rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .grant    (gnt_onehot),
        .idx      (gnt_idx),
        .any      (gnt_any)
    );

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;

    always_ff @(posedge pclk) begin
        if (!presetn || state != ACCESS) to_cnt <= '0;
        else                             to_cnt <= to_cnt + CNT_W'(1);
    end
    assign timeout_hit = (state == ACCESS) && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        finish    = 1'b0;
        ack       = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_any) begin
                    state_nxt = SETUP;
                    load      = 1'b1;
                end
            end
            SETUP: state_nxt = ACCESS;
            ACCESS: begin
                if (pready) begin
                    state_nxt = IDLE;
                    finish    = 1'b1;
                    ack       = 1'b1;
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                    finish    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign psel    = (state == SETUP) || (state == ACCESS);
    assign penable = (state == ACCESS);

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            owner_idx <= '0;
            owner_oh  <= '0;
            rr_ptr    <= '0;
            done      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            done <= '0;
            if (load) begin
                pwrite    <= req_write[gnt_idx];
                paddr     <= req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
                pwdata    <= req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
                owner_idx <= gnt_idx;
                owner_oh  <= gnt_onehot;
            end
            if (finish) begin
                done    <= owner_oh;
                rsp_err <= ack ? pslverr : 1'b1;
                rr_ptr  <= (owner_idx == IDX_W'(NUM_REQ - 1)) ? '0 : owner_idx + IDX_W'(1);
                if (ack && !pwrite) rsp_rdata <= prdata;
            end
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed plus randomized bench for apb_req_arbiter with a transaction-level reference model.
module tb_apb_req_arbiter;

    localparam int NR = 2;
    localparam int AW = 8;
    localparam int DW = 8;

    logic              pclk;
    logic              presetn;
    logic [NR-1:0]     req, req_write, done;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [DW-1:0]     rsp_rdata, pwdata, prdata;
    logic [AW-1:0]     paddr;
    logic              rsp_err, psel, penable, pwrite, pready, pslverr;

    apb_req_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)
    ) dut (
        .pclk(pclk), .presetn(presetn),
        .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: next search start, last read data, requester finishing this cycle.
    int            m_ptr   = 0;
    logic [DW-1:0] m_rdata = '0;
    logic [NR-1:0] m_done  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    function automatic int model_pick(input logic [NR-1:0] elig, input int ptr);
        for (int k = 0; k < NR; k++)
            if (elig[(ptr + k) % NR]) return (ptr + k) % NR;
        return -1;
    endfunction

    // Called in an IDLE cycle with req already set; runs one full transfer and checks every phase.
    task automatic run_xfer(input int waits, input logic [DW-1:0] rd, input logic err,
                            input bit scramble, output logic [NR-1:0] got_done);
        logic [NR-1:0] elig;
        int            own;
        logic [AW-1:0] ea;
        logic [DW-1:0] ew, exp_rd;
        logic          ewr;
        elig = req & ~m_done;
        if (elig == '0) begin
            chk("idle_wait_psel", 32'(psel), 32'd0);
            tick();
            m_done = '0;
            elig   = req;
        end
        own = model_pick(elig, m_ptr);
        if (own < 0) own = 0;
        ea  = req_addr[own*AW +: AW];
        ew  = req_wdata[own*DW +: DW];
        ewr = req_write[own];
        chk("idle_psel", 32'(psel), 32'd0);
        pready  = 1'b0;
        pslverr = 1'b0;
        tick();
        m_done = '0;
        chk("setup_psel", 32'(psel), 32'd1);
        chk("setup_penable", 32'(penable), 32'd0);
        chk("setup_paddr", 32'(paddr), 32'(ea));
        chk("setup_pwrite", 32'(pwrite), 32'(ewr));
        chk("setup_pwdata", 32'(pwdata), 32'(ew));
        if (scramble) begin
            req_addr  = 16'($urandom);
            req_wdata = 16'($urandom);
            req_write = 2'($urandom);
            req       = 2'($urandom);
        end
        tick();
        for (int w = 0; w < waits; w++) begin
            chk("wait_penable", 32'(penable), 32'd1);
            chk("wait_paddr", 32'(paddr), 32'(ea));
            chk("wait_pwdata", 32'(pwdata), 32'(ew));
            chk("wait_done", 32'(done), 32'd0);
            tick();
        end
        chk("access_psel", 32'(psel), 32'd1);
        chk("access_penable", 32'(penable), 32'd1);
        chk("access_paddr", 32'(paddr), 32'(ea));
        chk("access_pwrite", 32'(pwrite), 32'(ewr));
        pready  = 1'b1;
        prdata  = rd;
        pslverr = err;
        exp_rd  = ewr ? m_rdata : rd;
        tick();
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 8'($urandom);
        chk("done_vec", 32'(done), 32'(1 << own));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        chk("rsp_err", 32'(rsp_err), 32'(err));
        chk("done_psel", 32'(psel), 32'd0);
        m_rdata  = exp_rd;
        m_ptr    = (own + 1) % NR;
        m_done   = NR'(1 << own);
        got_done = done;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] d;
        presetn = 1'b0; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;
        tick(); tick(); tick();

        // Reset state
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_pwrite", 32'(pwrite), 32'd0);
        chk("rst_paddr", 32'(paddr), 32'd0);
        chk("rst_pwdata", 32'(pwdata), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        presetn = 1'b1;
        tick();
        chk("idle_no_req_psel", 32'(psel), 32'd0);

        // Single read, zero wait states
        req_addr[7:0] = 8'h12; req_write = 2'b00; req = 2'b01;
        run_xfer(0, 8'h5A, 1'b0, 1'b0, d);
        chk("t1_done", 32'(d), 32'h1);

        // Write with two wait states; read data must be preserved
        req = 2'b10; req_write = 2'b10; req_addr[15:8] = 8'h30; req_wdata[15:8] = 8'hC3;
        run_xfer(2, 8'hEE, 1'b0, 1'b0, d);
        chk("t2_done", 32'(d), 32'h2);
        chk("t2_rdata_kept", 32'(rsp_rdata), 32'h5A);

        // Round robin with both requests held
        req = 2'b11; req_write = 2'b00; req_addr = 16'h4433;
        for (int k = 0; k < 4; k++) begin
            run_xfer(k % 2, 8'(8'h80 + k), 1'b0, 1'b0, d);
            chk("rr_order", 32'(d), (k % 2 == 0) ? 32'h1 : 32'h2);
        end

        // Slave error then clean transfer
        run_xfer(1, 8'h77, 1'b1, 1'b0, d);
        chk("err_flag", 32'(rsp_err), 32'd1);
        run_xfer(0, 8'h11, 1'b0, 1'b0, d);
        chk("err_cleared", 32'(rsp_err), 32'd0);

        // Reset during ACCESS wait: advance pointer to 1 first so reset's effect is visible
        req = 2'b01;
        run_xfer(0, 8'h22, 1'b0, 1'b0, d);
        req = 2'b10;
        tick();
        chk("mid_setup_psel", 32'(psel), 32'd1);
        tick();
        chk("mid_access_penable", 32'(penable), 32'd1);
        tick();
        chk("mid_wait_penable", 32'(penable), 32'd1);
        presetn = 1'b0; req = '0;
        tick();
        chk("mid_rst_psel", 32'(psel), 32'd0);
        chk("mid_rst_penable", 32'(penable), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        presetn = 1'b1;
        tick();
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_rdata", 32'(rsp_rdata), 32'd0);
        m_ptr = 0; m_rdata = '0; m_done = '0;
        req = 2'b11;
        run_xfer(0, 8'h33, 1'b0, 1'b0, d);
        chk("post_rst_owner", 32'(d), 32'h1);

        // Randomized traffic, including late changes to requester inputs
        for (int i = 0; i < 40; i++) begin
            req       = 2'($urandom_range(1, 3));
            req_write = 2'($urandom);
            req_addr  = 16'($urandom);
            req_wdata = 16'($urandom);
            run_xfer(int'($urandom_range(0, 3)), 8'($urandom), ($urandom_range(0, 3) == 0), 1'b1, d);
        end

`ifdef APB_ARB_TIMEOUT_EN
        // Slave never ready: ends after 4 ACCESS cycles with an error
        req = '0;
        tick();
        m_done = '0;
        req = 2'b01; req_write = 2'b00;
        d = NR'(1 << model_pick(2'b01, m_ptr));
        tick();
        chk("to_setup_psel", 32'(psel), 32'd1);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("to_access_penable", 32'(penable), 32'd1);
            chk("to_access_done", 32'(done), 32'd0);
            tick();
        end
        chk("to_done", 32'(done), 32'(d));
        chk("to_err", 32'(rsp_err), 32'd1);
        chk("to_rdata", 32'(rsp_rdata), 32'(m_rdata));
        chk("to_psel", 32'(psel), 32'd0);
        req = '0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Shares one APB master port between NUM_REQ on-chip requesters (e.g. sensor sequencer, I2C register bridge) using round-robin arbitration.
- Sequences the APB IDLE -> SETUP -> ACCESS protocol, waits on pready, and returns read data and error status to the granted requester.
- Sits between the requester logic and the APB slaves (i2c_slave register block, etc.).

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- ADDR_W, 8: APB address width.
- DATA_W, 8: APB data width.
- TIMEOUT_CYCLES, 16: ACCESS-phase wait limit; used only with the optional feature.

Ports:
- pclk  in  1  clock.
- presetn  in  1  reset, synchronous, active-low.
- req  in  NUM_REQ  per-requester transfer request; level, held until done.
- req_write  in  NUM_REQ  1 = write, 0 = read, per requester.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data; same packing.
- done  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- rsp_rdata  out  DATA_W  read data, valid while any done bit is high.
- rsp_err  out  1  pslverr (or timeout) of the completed transfer, valid with done.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Clock and reset: single clock pclk. presetn is synchronous and active-low.
- Reset state: state = IDLE, rr_ptr = 0, all outputs 0 (psel, penable, pwrite, paddr, pwdata, done, rsp_rdata, rsp_err).
- FSM states: IDLE, SETUP, ACCESS.
- psel = (SETUP | ACCESS); penable = ACCESS.
- paddr, pwdata and pwrite are registers loaded only on a grant, and stay stable SETUP through ACCESS.
- IDLE:
  - The eligible set is req, masked by the done bits asserted this cycle. This prevents re-granting a requester that has not yet dropped req.
  - If the eligible set is non-empty, grant the first set bit searching from rr_ptr upward with wrap-around.
  - On a grant, latch that requester's addr, wdata and write into the APB registers, store the owner index, and go to SETUP.
  - Otherwise stay in IDLE.
- SETUP -> ACCESS unconditionally after 1 cycle.
- ACCESS:
  - While pready = 0, hold all signals.
  - When pready = 1:
    - capture prdata into rsp_rdata (reads only; writes leave it unchanged) and pslverr into rsp_err;
    - assert done[owner] on the next cycle;
    - set rr_ptr = owner + 1, wrapping to 0 at NUM_REQ;
    - go to IDLE.
- Latency: req sampled high in IDLE at cycle N gives psel at N+1, penable at N+2, and done at M+1, where M is the first ACCESS cycle with pready = 1. With zero wait states, done arrives at N+3.
- Back-to-back: minimum 3 cycles per transfer; the IDLE cycle is the done cycle.
- req dropped mid-transfer: the transfer completes and done still pulses. Requester inputs are ignored outside IDLE.
- Changes to req_addr, req_wdata or req_write after grant are ignored.
- Simultaneous requests resolve by round-robin only; there is no fixed priority.
- Reset mid-transfer: returns to IDLE on the next edge. psel, penable and done drop, and no done is issued for the aborted transfer.

Optional Feature:
- APB_ARB_TIMEOUT_EN defined:
  - A counter runs during ACCESS.
  - If pready is still 0 after TIMEOUT_CYCLES ACCESS cycles, the transfer is ended: done[owner] pulses with rsp_err = 1, rsp_rdata is unchanged, rr_ptr advances, and the FSM returns to IDLE.
- Undefined: no counter logic; ACCESS waits on pready indefinitely.

Decomposition:
- Shared package apb_arb_pkg: state enum (IDLE, SETUP, ACCESS) and default width constants.
- One sub-module, rr_arbiter: combinational round-robin pick (eligible vector + rr_ptr -> one-hot grant + index). It is reusable elsewhere.
- State register uses the team dff cell.

Test Plan:
- Single read, zero wait: req[0] = 1, addr 0x12, prdata 0x5A, pready = 1 -> psel at N+1, penable at N+2, done[0] at N+3, rsp_rdata = 0x5A, rsp_err = 0.
- Write with 2 wait states: req[1] write, addr 0x30, wdata 0xC3, pready low 2 ACCESS cycles -> paddr/pwdata stable throughout, done[1] 1 cycle after pready rises.
- Round-robin: req = 2'b11 held continuously -> grants alternate 0,1,0,1; no requester is granted twice in a row.
- Error: pslverr = 1 with pready -> rsp_err = 1 with done; next transfer rsp_err = 0.
- Reset mid-ACCESS: presetn low during wait state -> next cycle psel = penable = 0, no done, rr_ptr = 0.
- APB_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES = 4, pready stuck low -> done with rsp_err = 1 after 4 ACCESS cycles, FSM back in IDLE.
